// File: rtl/peak_pkg.sv
// Shared definitions for the solar-tracker calibration sweep blocks:
// FSM state encoding of the peak return counter and default sizing
// constants used by the sweep counters and the servo control FSM.
package peak_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_REWIND = 2'd2,
        ST_FIN    = 2'd3
    } peak_state_e;

    localparam int PEAK_WIDTH   = 13;
    localparam int PEAK_TIMEOUT = 1023;
    localparam int PEAK_TO_W    = 10;

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter: synchronous clear has priority, increment
// holds at all-ones, decrement holds at zero. is_zero / is_max are decoded
// from the registered count.
module sat_updown_counter #(
    parameter int WIDTH = 13
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_is_zero,
    output logic             o_is_max
);

    logic [WIDTH-1:0] r_count;
    logic             w_is_zero;
    logic             w_is_max;

    assign w_is_zero = (r_count == {WIDTH{1'b0}});
    assign w_is_max  = (&r_count);

    // Count register: clear, saturating increment, zero-guarded decrement.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_inc && !w_is_max) begin
            r_count <= r_count + WIDTH'(1);
        end else if (i_dec && !w_is_zero) begin
            r_count <= r_count - WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count   = r_count;
    assign o_is_zero = w_is_zero;
    assign o_is_max  = w_is_max;

endmodule

// File: rtl/peak_return_counter.sv
// Peak return counter: counts servo steps since the last voltage maximum
// during a sweep, then rewinds the servo one step per count through a
// RET_REQ/RET_ACK handshake. All outputs are registered.
// Optional build macro PEAK_RETURN_TIMEOUT_EN adds a REWIND watchdog that
// aborts to IDLE with a sticky ERR when RET_ACK does not arrive in time.
module peak_return_counter
    import peak_pkg::*;
#(
    parameter int WIDTH   = PEAK_WIDTH,
    parameter int TIMEOUT = PEAK_TIMEOUT,
    parameter int TO_W    = PEAK_TO_W
) (
    input  logic             CLK,
    input  logic             CNT_RST,
    input  logic             SWEEP_START,
    input  logic             STEP,
    input  logic             NEW_MAX,
    input  logic             SWEEP_END,
    input  logic             RET_ACK,
    output logic             RET_REQ,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF,
    output logic             ERR,
    output logic [WIDTH-1:0] COUNT
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    peak_state_e      r_state;
    peak_state_e      w_state_nxt;
    logic             r_ret_req;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count;
    logic             w_is_zero;
    logic             w_is_max;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;
    logic             w_ack_ok;
    logic             w_last;
    logic             w_upd_zero;
    logic             w_to_hit;
    logic             w_ret_req_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_ovf_nxt;

    // An ACK only counts while a request is outstanding.
    assign w_ack_ok   = RET_ACK && r_ret_req;
    assign w_last     = (w_count == WIDTH'(1));
    // Count after this cycle's STEP/NEW_MAX update is zero: a new maximum
    // clears it, otherwise it stays zero only if no step arrives.
    assign w_upd_zero = NEW_MAX || (w_is_zero && !STEP);

    sat_updown_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .i_clk     (CLK),
        .i_rst     (CNT_RST),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .o_count   (w_count),
        .o_is_zero (w_is_zero),
        .o_is_max  (w_is_max)
    );

`ifdef PEAK_RETURN_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_to_hit = (r_state == ST_REWIND) && r_ret_req && !RET_ACK &&
                      (r_to_cnt == TO_LIMIT);

    // Watchdog: held at zero outside REWIND and on each ACK, counts stalls.
    always_ff @(posedge CLK or posedge CNT_RST) begin
        if (CNT_RST) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if ((r_state != ST_REWIND) || RET_ACK) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (r_ret_req) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    // Sticky timeout error, cleared when a new sweep starts.
    always_ff @(posedge CLK or posedge CNT_RST) begin
        if (CNT_RST) begin
            r_err <= 1'b0;
        end else if (w_to_hit) begin
            r_err <= 1'b1;
        end else if ((r_state == ST_IDLE) && SWEEP_START) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end

    assign ERR = r_err;
`else
    logic w_unused_cfg;

    assign w_to_hit     = 1'b0;
    assign w_unused_cfg = ^TO_LIMIT;
    assign ERR          = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge CNT_RST) begin
        if (CNT_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (SWEEP_START) begin
                    w_state_nxt = ST_SWEEP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (SWEEP_START) begin
                    w_state_nxt = ST_SWEEP;
                end else if (SWEEP_END) begin
                    w_state_nxt = w_upd_zero ? ST_FIN : ST_REWIND;
                end else begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            ST_REWIND: begin
                if (w_ack_ok && w_last) begin
                    w_state_nxt = ST_FIN;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REWIND;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output / datapath control decode.
    always_comb begin
        w_clr         = 1'b0;
        w_inc         = 1'b0;
        w_dec         = 1'b0;
        w_ovf_nxt     = r_ovf;
        w_ret_req_nxt = (w_state_nxt == ST_REWIND);
        w_busy_nxt    = (w_state_nxt == ST_SWEEP) || (w_state_nxt == ST_REWIND);
        w_done_nxt    = (r_state == ST_FIN);
        case (r_state)
            ST_IDLE: begin
                if (SWEEP_START) begin
                    w_clr     = 1'b1;
                    w_ovf_nxt = 1'b0;
                end else begin
                    w_ovf_nxt = r_ovf;
                end
            end
            ST_SWEEP: begin
                if (SWEEP_START) begin
                    w_clr     = 1'b1;
                    w_ovf_nxt = 1'b0;
                end else if (NEW_MAX) begin
                    w_clr     = 1'b1;
                end else if (STEP) begin
                    w_inc     = 1'b1;
                    w_ovf_nxt = r_ovf || w_is_max;
                end else begin
                    w_ovf_nxt = r_ovf;
                end
            end
            ST_REWIND: begin
                w_dec = w_ack_ok;
            end
            ST_FIN: begin
                w_dec = 1'b0;
            end
            default: begin
                w_dec = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge CLK or posedge CNT_RST) begin
        if (CNT_RST) begin
            r_ret_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ret_req <= w_ret_req_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign RET_REQ = r_ret_req;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign OVF     = r_ovf;
    assign COUNT   = w_count;

endmodule

// File: tb/tb_peak_return_counter.sv
// Directed testbench for peak_return_counter (WIDTH=4, TIMEOUT=8).
module tb_peak_return_counter;

    logic       clk;
    logic       rst;
    logic       start;
    logic       step;
    logic       new_max;
    logic       send;
    logic       ack;
    logic       ret_req;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       err;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    peak_return_counter #(
        .WIDTH   (4),
        .TIMEOUT (8),
        .TO_W    (4)
    ) dut (
        .CLK         (clk),
        .CNT_RST     (rst),
        .SWEEP_START (start),
        .STEP        (step),
        .NEW_MAX     (new_max),
        .SWEEP_END   (send),
        .RET_ACK     (ack),
        .RET_REQ     (ret_req),
        .BUSY        (busy),
        .DONE        (done),
        .OVF         (ovf),
        .ERR         (err),
        .COUNT       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step = 1'b1; cyc(); step = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; step = 1'b0; new_max = 1'b0;
        send = 1'b0; ack = 1'b0;
        #2;
        checks++;
        if ({ret_req, busy, done, ovf, err} !== 5'b00000) begin
            $display("FAIL reset_flags: got %b expected 00000", {ret_req, busy, done, ovf, err});
            errors++;
        end
        checks++;
        if (count !== 4'd0) begin
            $display("FAIL reset_count: got %0d expected 0", count);
            errors++;
        end
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_ignored_in_idle();
        step = 1'b1; ack = 1'b1; new_max = 1'b1; send = 1'b1;
        cyc(); cyc();
        step = 1'b0; ack = 1'b0; new_max = 1'b0; send = 1'b0;
        checks++;
        if ({busy, ret_req, done, count} !== 7'd0) begin
            $display("FAIL idle_ignore: got busy=%b req=%b done=%b count=%0d expected all 0",
                     busy, ret_req, done, count);
            errors++;
        end
    endtask

    task automatic test_basic_rewind();
        int acks;
        do_start();
        checks++;
        if (busy !== 1'b1 || count !== 4'd0) begin
            $display("FAIL basic_start: got busy=%b count=%0d expected busy=1 count=0", busy, count);
            errors++;
        end
        do_steps(3);
        new_max = 1'b1; cyc(); new_max = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            $display("FAIL basic_newmax_clear: got %0d expected 0", count);
            errors++;
        end
        do_steps(7);
        checks++;
        if (count !== 4'd7) begin
            $display("FAIL basic_count7: got %0d expected 7", count);
            errors++;
        end
        send = 1'b1; cyc(); send = 1'b0;
        checks++;
        if (ret_req !== 1'b1 || busy !== 1'b1 || count !== 4'd7) begin
            $display("FAIL basic_rewind_entry: got req=%b busy=%b count=%0d expected 1 1 7",
                     ret_req, busy, count);
            errors++;
        end
        acks = 0;
        ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (ret_req !== 1'b1) break;
            cyc();
            acks++;
        end
        ack = 1'b0;
        checks++;
        if (acks !== 7) begin
            $display("FAIL basic_ack_count: got %0d expected 7", acks);
            errors++;
        end
        checks++;
        if (count !== 4'd0 || ret_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_fin: got count=%0d req=%b done=%b busy=%b expected 0 0 0 0",
                     count, ret_req, done, busy);
            errors++;
        end
        cyc();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL basic_done_pulse: got done=%b busy=%b expected 1 0", done, busy);
            errors++;
        end
        cyc();
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL basic_done_single: got %b expected 0", done);
            errors++;
        end
    endtask

    task automatic test_max_at_end();
        do_start();
        do_steps(2);
        step = 1'b1; new_max = 1'b1; cyc(); step = 1'b0; new_max = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            $display("FAIL maxend_priority: got %0d expected 0", count);
            errors++;
        end
        send = 1'b1; cyc(); send = 1'b0;
        checks++;
        if (ret_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL maxend_fin: got req=%b done=%b busy=%b expected 0 0 0",
                     ret_req, done, busy);
            errors++;
        end
        cyc();
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL maxend_done: got %b expected 1", done);
            errors++;
        end
        cyc();
    endtask

    task automatic test_coincident_end();
        // STEP from zero together with SWEEP_END: updated count 1 -> rewind.
        do_start();
        step = 1'b1; send = 1'b1; cyc(); step = 1'b0; send = 1'b0;
        checks++;
        if (ret_req !== 1'b1 || count !== 4'd1) begin
            $display("FAIL coinc_step_end: got req=%b count=%0d expected 1 1", ret_req, count);
            errors++;
        end
        ack = 1'b1; cyc(); ack = 1'b0;
        checks++;
        if (ret_req !== 1'b0 || count !== 4'd0) begin
            $display("FAIL coinc_one_ack: got req=%b count=%0d expected 0 0", ret_req, count);
            errors++;
        end
        cyc();
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL coinc_done: got %b expected 1", done);
            errors++;
        end
        cyc();
    endtask

    task automatic test_saturation();
        int acks;
        do_start();
        checks++;
        if (ovf !== 1'b0) begin
            $display("FAIL sat_ovf_clear: got %b expected 0", ovf);
            errors++;
        end
        do_steps(15);
        checks++;
        if (count !== 4'd15 || ovf !== 1'b0) begin
            $display("FAIL sat_at_max: got count=%0d ovf=%b expected 15 0", count, ovf);
            errors++;
        end
        do_steps(5);
        checks++;
        if (count !== 4'd15 || ovf !== 1'b1) begin
            $display("FAIL sat_overflow: got count=%0d ovf=%b expected 15 1", count, ovf);
            errors++;
        end
        send = 1'b1; cyc(); send = 1'b0;
        acks = 0;
        ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (ret_req !== 1'b1) break;
            cyc();
            acks++;
        end
        ack = 1'b0;
        checks++;
        if (acks !== 15) begin
            $display("FAIL sat_ack_count: got %0d expected 15", acks);
            errors++;
        end
        cyc();
        checks++;
        if (done !== 1'b1 || ovf !== 1'b1 || count !== 4'd0) begin
            $display("FAIL sat_done: got done=%b ovf=%b count=%0d expected 1 1 0", done, ovf, count);
            errors++;
        end
        cyc();
    endtask

    task automatic test_slow_ack();
        int exp_cnt;
        do_start();
        checks++;
        if (ovf !== 1'b0) begin
            $display("FAIL slow_ovf_restart: got %b expected 0", ovf);
            errors++;
        end
        do_steps(3);
        send = 1'b1; cyc(); send = 1'b0;
        exp_cnt = 3;
        for (int i = 0; i < 15; i++) begin
            ack     = ((i % 5) == 4);
            step    = (i == 1);
            new_max = (i == 2);
            start   = (i == 3);
            send    = (i == 3);
            cyc();
            if (ack && exp_cnt > 0) exp_cnt--;
            ack = 1'b0; step = 1'b0; new_max = 1'b0; start = 1'b0; send = 1'b0;
            checks++;
            if (count !== 4'(exp_cnt) || ret_req !== (exp_cnt != 0)) begin
                $display("FAIL slow_ack_cycle%0d: got count=%0d req=%b expected count=%0d req=%b",
                         i, count, ret_req, exp_cnt, (exp_cnt != 0));
                errors++;
            end
        end
        cyc();
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL slow_done: got %b expected 1", done);
            errors++;
        end
        cyc();
    endtask

    task automatic test_reset_mid_rewind();
        int acks;
        do_start();
        do_steps(6);
        send = 1'b1; cyc(); send = 1'b0;
        ack = 1'b1; cyc(); cyc(); ack = 1'b0;
        checks++;
        if (count !== 4'd4 || ret_req !== 1'b1) begin
            $display("FAIL rstmid_setup: got count=%0d req=%b expected 4 1", count, ret_req);
            errors++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ret_req, busy, done, ovf, err} !== 5'b00000 || count !== 4'd0) begin
            $display("FAIL rstmid_async: got flags=%b count=%0d expected 00000 0",
                     {ret_req, busy, done, ovf, err}, count);
            errors++;
        end
        cyc();
        rst = 1'b0;
        cyc(); cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rstmid_no_done: got done=%b busy=%b expected 0 0", done, busy);
            errors++;
        end
        do_start();
        do_steps(2);
        checks++;
        if (count !== 4'd2 || busy !== 1'b1) begin
            $display("FAIL rstmid_restart: got count=%0d busy=%b expected 2 1", count, busy);
            errors++;
        end
        send = 1'b1; cyc(); send = 1'b0;
        acks = 0;
        ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (ret_req !== 1'b1) break;
            cyc();
            acks++;
        end
        ack = 1'b0;
        cyc();
        checks++;
        if (acks !== 2 || done !== 1'b1) begin
            $display("FAIL rstmid_rewind: got acks=%0d done=%b expected 2 1", acks, done);
            errors++;
        end
        cyc();
    endtask

`ifdef PEAK_RETURN_TIMEOUT_EN
    task automatic test_timeout();
        do_start();
        do_steps(2);
        send = 1'b1; cyc(); send = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            checks++;
            if (err !== (i == 8)) begin
                $display("FAIL timeout_err_cycle%0d: got %b expected %b", i, err, (i == 8));
                errors++;
            end
        end
        checks++;
        if (ret_req !== 1'b0 || count !== 4'd2 || busy !== 1'b0) begin
            $display("FAIL timeout_abort: got req=%b count=%0d busy=%b expected 0 2 0",
                     ret_req, count, busy);
            errors++;
        end
        cyc();
        checks++;
        if (done !== 1'b0 || err !== 1'b1) begin
            $display("FAIL timeout_no_done: got done=%b err=%b expected 0 1", done, err);
            errors++;
        end
        do_start();
        checks++;
        if (err !== 1'b0) begin
            $display("FAIL timeout_err_clear: got %b expected 0", err);
            errors++;
        end
        send = 1'b1; cyc(); send = 1'b0;
        cyc(); cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_ignored_in_idle();
        test_basic_rewind();
        test_max_at_end();
        test_coincident_end();
        test_saturation();
        test_slow_ack();
        test_reset_mid_rewind();
`ifdef PEAK_RETURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_return_counter.md
Name: peak_return_counter

Overview:
- Parametrised position-offset counter for the solar-tracker calibration sweep.
- During a sweep it counts servo steps since the last detected voltage maximum; each new maximum clears the count.
- At sweep end it rewinds: it issues one return-step request per counted step through a req/ack handshake with the servo FSM, leaving the servo on the maximum.
- Sits between the max comparator, the horizontal/vertical sweep counters and the servo control FSM; one instance per axis.

Parameters:
- WIDTH, 13, count width in bits; maximum trackable offset is 2^WIDTH-1 steps.
- TIMEOUT, 1023, cycles allowed between RET_REQ assertion and RET_ACK (used only with the optional feature).
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- CNT_RST  in  1  asynchronous, active-high reset.
- SWEEP_START  in  1  single-cycle pulse: begin a sweep and clear the count.
- STEP  in  1  single-cycle pulse: the servo advanced one sweep step.
- NEW_MAX  in  1  single-cycle pulse: the comparator latched a new maximum at the current position.
- SWEEP_END  in  1  single-cycle pulse: the sweep counter reached its end of travel.
- RET_ACK  in  1  servo FSM completed one return step.
- RET_REQ  out  1  request one step back toward the maximum.
- BUSY  out  1  high in SWEEP or REWIND.
- DONE  out  1  single-cycle pulse when the servo is back on the maximum.
- OVF  out  1  sticky: the count saturated during this sweep.
- ERR  out  1  sticky timeout error (optional feature; otherwise tied 0).
- COUNT  out  WIDTH  current offset count.

Behaviour:
- Reset (asynchronous, CNT_RST=1): state IDLE; COUNT=0; RET_REQ=0; BUSY=0; DONE=0; OVF=0; ERR=0.
- All other updates occur on the CLK rising edge. Outputs are registered, so responses appear one cycle after the causing input.
- States: IDLE, SWEEP, REWIND, FIN.
- IDLE:
  - SWEEP_START -> SWEEP; COUNT<=0; OVF<=0; ERR<=0.
  - STEP, NEW_MAX, SWEEP_END and RET_ACK are ignored.
- SWEEP:
  - STEP alone: COUNT<=COUNT+1, saturating at 2^WIDTH-1.
  - STEP while COUNT is already all-ones: COUNT holds and OVF<=1.
  - NEW_MAX: COUNT<=0. NEW_MAX has priority over a STEP in the same cycle, so COUNT=0 (the max is the current position).
  - SWEEP_END: if COUNT==0 -> FIN; otherwise -> REWIND with RET_REQ<=1.
  - SWEEP_END in the same cycle as STEP or NEW_MAX: apply the STEP/NEW_MAX update first, then evaluate the COUNT==0 test on the updated value.
  - SWEEP_START in SWEEP restarts the sweep: COUNT<=0, OVF<=0.
- REWIND:
  - RET_REQ stays high until acknowledged.
  - RET_ACK: COUNT<=COUNT-1. If the new COUNT==0: RET_REQ<=0 and -> FIN. Otherwise RET_REQ stays 1; the next step is requested back-to-back.
  - COUNT never wraps below 0; RET_REQ is never high while COUNT==0.
  - STEP, NEW_MAX, SWEEP_END and SWEEP_START are ignored.
  - RET_ACK while RET_REQ=0 is ignored.
- FIN: DONE=1 for exactly one cycle, then -> IDLE. COUNT is 0 and OVF is retained.
- BUSY = (state==SWEEP || state==REWIND), registered.
- CNT_RST mid-REWIND: immediate abort; RET_REQ drops asynchronously; no DONE pulse.

Optional Feature:
- Macro: PEAK_RETURN_TIMEOUT_EN.
- Defined:
  - A TO_W-bit watchdog clears on entry to REWIND and on each RET_ACK, and increments every cycle RET_REQ=1 without RET_ACK.
  - On reaching TIMEOUT: ERR<=1 (sticky until the next SWEEP_START or reset); RET_REQ<=0; COUNT holds the remaining offset; -> IDLE; no DONE pulse.
- Undefined: no watchdog logic; ERR tied 0; REWIND waits indefinitely.

Decomposition:
- Shared package peak_pkg:
  - state encoding (IDLE=2'd0, SWEEP=2'd1, REWIND=2'd2, FIN=2'd3);
  - default WIDTH/TIMEOUT constants, shared with the sweep counter and servo FSM.
- One natural sub-module, sat_updown_counter (WIDTH):
  - sync clear, saturating increment, decrement guarded at 0;
  - outputs is_zero and is_max.
- FSM and handshake stay in the top module.

Test Plan:
- Basic rewind: SWEEP_START; 10 STEP with NEW_MAX after step 3; 7 more steps counted (COUNT=7); SWEEP_END -> RET_REQ=1; ack each cycle -> exactly 7 ACKs consumed, COUNT=0, RET_REQ low, DONE one cycle, BUSY low.
- Max at end of sweep: NEW_MAX coincident with the last STEP, then SWEEP_END -> COUNT=0, no RET_REQ, DONE pulse 2 cycles after SWEEP_END.
- Saturation (WIDTH=4): 20 STEP without NEW_MAX -> COUNT=15, OVF=1; rewind consumes 15 ACKs, then DONE.
- Slow ACK: RET_ACK every 5th cycle for COUNT=3 -> RET_REQ held continuously, COUNT decrements 3->2->1->0 only on ACK cycles.
- Reset mid-REWIND at COUNT=4 -> all outputs 0 immediately; later SWEEP_START works normally.
- PEAK_RETURN_TIMEOUT_EN with TIMEOUT=8: REWIND with no ACK -> ERR=1 on cycle 8, RET_REQ=0, COUNT unchanged, no DONE.
